// File: rtl/uart_rx.sv
// AXI4-Stream UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
// Mid-bit sampling with a prescale*8 clock bit period; framing/overrun errors as single-cycle pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                state, state_next;
  logic                  rxd_meta, rxd_s, rxd_prev;
  logic [1:0]            warm;
  logic [15:0]           p_eff, p_lat;
  logic [18:0]           cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  tick, start_det, load_bit, sample_bit, word_done, stop_bad;

  assign tick  = (cnt == '0);
  assign p_eff = (prescale == 16'd0) ? 16'd1 : prescale;

  // rxd_prev only follows rxd_s once the synchroniser holds real line samples,
  // so a line held low through reset is never mistaken for a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      warm     <= 2'b00;
      rxd_prev <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      warm     <= {warm[0], 1'b1};
      rxd_prev <= warm[1] & rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    load_bit   = 1'b0;
    sample_bit = 1'b0;
    word_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rxd_prev && !rxd_s) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (rxd_s) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            load_bit   = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_bit = 1'b1;
          load_bit   = 1'b1;
          if (bit_idx == IW'(DATA_WIDTH - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxd_s) begin
            state_next = IDLE;
            word_done  = 1'b1;
          end else begin
            state_next = BREAK;
            stop_bad   = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer, shift register and AXI-Stream output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_lat         <= 16'd0;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      busy          <= (state_next != IDLE);
      frame_error   <= stop_bad;
      overrun_error <= 1'b0;

      if (start_det) begin
        p_lat <= p_eff;
        cnt   <= {1'b0, p_eff, 2'b00} - 19'd1;
      end else if (load_bit) begin
        cnt <= {p_lat, 3'b000} - 19'd1;
      end else if (!tick) begin
        cnt <= cnt - 19'd1;
      end

      if (state == START)   bit_idx <= '0;
      else if (sample_bit)  bit_idx <= bit_idx + 1'b1;

      if (sample_bit)
        shift_reg <= (shift_reg >> 1) | (DATA_WIDTH'(rxd_s) << (DATA_WIDTH - 1));

      if (word_done) begin
        m_axis_tdata  <= shift_reg;
        m_axis_tvalid <= 1'b1;
        overrun_error <= m_axis_tvalid && !m_axis_tready;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serialiser task drives rxd and queues expected words,
// a negedge monitor pops and compares on every AXI transfer and counts error pulses.
module tb_uart_rx;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          rxd;
  logic          busy;
  logic          overrun_error;
  logic          frame_error;
  logic [15:0]   prescale;

  logic [DW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            fe_cnt = 0;
  int            ov_cnt = 0;
  int            exp_fe = 0;
  int            exp_ov = 0;
  int            p = 1;
  bit            rand_ready = 1'b0;
  bit            busy_seen = 1'b0;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serialise one frame onto rxd; the line is left at the stop-bit level.
  task automatic applyStimulus(input logic [DW-1:0] word, input logic stop_bit);
    rxd = 1'b0;
    repeat (8 * p) @(posedge clk);
    #1;
    for (int i = 0; i < DW; i++) begin
      rxd = word[i];
      repeat (8 * p) @(posedge clk);
      #1;
    end
    rxd = stop_bit;
    repeat (8 * p) @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [DW-1:0] word);
    exp_q.push_back(word);
    applyStimulus(word, 1'b1);
  endtask

  task automatic checkPhase(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    checkOutput({name, "_pending"}, exp_q.size(), 0);
    checkOutput({name, "_frame_err"}, fe_cnt, exp_fe);
    checkOutput({name, "_overrun"}, ov_cnt, exp_ov);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error)   fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (busy)          busy_seen = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected none at %0t", m_axis_tdata, $time);
        end else begin
          checkOutput("rx_word", m_axis_tdata, exp_q.pop_front());
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rxd           = 1'b1;
    m_axis_tready = 1'b0;
    prescale      = 16'd1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_err", frame_error, 0);
    checkOutput("rst_overrun", overrun_error, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single word at P=1 with the 3-cycle stop-midpoint-to-tvalid latency.
    $display("[TB] single word 0x1A5, P=1");
    m_axis_tready = 1'b1;
    p = 1;
    prescale = 16'd1;
    fork
      sendWord(9'h1A5);
      begin
        repeat (4 * p + 8 * p * (DW + 1) + 2) @(posedge clk);
        #2;
        checkOutput("latency_tvalid_early", m_axis_tvalid, 0);
        @(posedge clk);
        #2;
        checkOutput("latency_tvalid_on_time", m_axis_tvalid, 1);
      end
    join
    checkPhase("single");

    $display("[TB] back-to-back 0x000, 0x1FF, P=4");
    p = 4;
    prescale = 16'd4;
    sendWord(9'h000);
    sendWord(9'h1FF);
    checkPhase("b2b");

    $display("[TB] start glitch, P=2");
    p = 2;
    prescale = 16'd2;
    busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    checkOutput("glitch_busy_seen", busy_seen, 1);
    checkOutput("glitch_busy_end", busy, 0);
    checkPhase("glitch");

    $display("[TB] stop bit low on 0x055, P=2");
    applyStimulus(9'h055, 1'b0);
    exp_fe++;
    repeat (16 * p) @(posedge clk);
    #2;
    checkOutput("break_busy_held", busy, 1);
    checkOutput("break_tvalid", m_axis_tvalid, 0);
    rxd = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    checkOutput("break_busy_released", busy, 0);
    checkPhase("frame_err");

    $display("[TB] overrun 0x011 then 0x022 with tready low, P=1");
    p = 1;
    prescale = 16'd1;
    m_axis_tready = 1'b0;
    applyStimulus(9'h011, 1'b1);
    sendWord(9'h022);
    exp_ov++;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("overrun_tdata", m_axis_tdata, 9'h022);
    checkOutput("overrun_tvalid", m_axis_tvalid, 1);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    checkPhase("overrun");

    $display("[TB] reset during data bit 4, then 0x133, P=2");
    p = 2;
    prescale = 16'd2;
    rxd = 1'b0;
    repeat (8 * p) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      repeat (8 * p) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (4 * p) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midreset_busy", busy, 0);
    rxd = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    sendWord(9'h133);
    checkPhase("midreset");

    $display("[TB] random words with random tready");
    rand_ready = 1'b1;
    p = 1;
    prescale = 16'd1;
    for (int i = 0; i < 256; i++) sendWord(DW'($urandom_range(0, 511)));
    checkPhase("rand_p1");
    p = 7;
    prescale = 16'd7;
    for (int i = 0; i < 32; i++) sendWord(DW'($urandom_range(0, 511)));
    checkPhase("rand_p7");
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
